locked_mult_key_scanner: RTL and testbench

Sequencer that drives the XOR-locked 8x8 array multiplier (64-bit key input) through a key-candidate sweep. For each candidate it applies a fixed pseudo-random operand sequence, compares the multiplier product against an internally computed golden product, and reports a per-candidate mismatch count over a valid/ready handshake. It sits between the locked multiplier instance and the key-characterisation logic or bench, replacing hand-written per-key stimulus.

---
 rtl/locked_mult_key_scanner.sv | 182 ++++++++++++++++++
 tb/tb_locked_mult_key_scanner.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/locked_mult_key_scanner.sv
// Key-candidate sweep sequencer for the XOR-locked 8x8 multiplier.
// Applies an LFSR operand sequence per candidate and reports mismatch counts.
module locked_mult_key_scanner #(
    parameter  int KEY_W  = 64,
    parameter  int N_VEC  = 16,
    parameter  int SETTLE = 2,
    localparam int ERR_W  = $clog2(N_VEC + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [KEY_W-1:0] base_key_i,
    input  logic [15:0]      seed_i,
    output logic [7:0]       operand1_o,
    output logic [7:0]       operand2_o,
    output logic [KEY_W-1:0] key_o,
    input  logic [15:0]      result_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [6:0]       res_idx_o,
    output logic [ERR_W-1:0] res_err_o,
    output logic             busy_o,
    output logic             done_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_APPLY,
        S_CHECK,
        S_REPORT,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [KEY_W-1:0]   key_q, key_d;
    logic [KEY_W-1:0]   base_q, base_d;
    logic [15:0]        lfsr_q, lfsr_d;
    logic [15:0]        seed_q, seed_d;
    logic [6:0]         k_q, k_d;
    logic [7:0]         vec_q, vec_d;
    logic [7:0]         settle_q, settle_d;
    logic [ERR_W-1:0]   err_q, err_d;

    logic [15:0]        seed_eff;
    logic [15:0]        lfsr_nxt;
    logic [15:0]        golden;
    logic               mismatch;

    // Seed fix-up, LFSR step and golden product.
    always_comb begin
        seed_eff = (seed_i == 16'd0) ? 16'hACE1 : seed_i;
        lfsr_nxt = {lfsr_q[14:0],
                    lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        golden   = {8'd0, lfsr_q[15:8]} * {8'd0, lfsr_q[7:0]};
        mismatch = (result_i != golden);
    end

    // Next-state and datapath updates; abort overrides everything.
    always_comb begin
        state_d  = state_q;
        key_d    = key_q;
        base_d   = base_q;
        lfsr_d   = lfsr_q;
        seed_d   = seed_q;
        k_d      = k_q;
        vec_d    = vec_q;
        settle_d = settle_q;
        err_d    = err_q;
        if (abort_i) begin
            state_d  = S_IDLE;
            key_d    = '0;
            lfsr_d   = '0;
            k_d      = '0;
            vec_d    = '0;
            settle_d = '0;
            err_d    = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        base_d  = base_key_i;
                        seed_d  = seed_eff;
                        lfsr_d  = seed_eff;
                        key_d   = base_key_i;
                        k_d     = '0;
                        vec_d   = '0;
                        err_d   = '0;
                        state_d = S_LOAD;
                    end
                end
                S_LOAD: begin
                    settle_d = '0;
                    state_d  = S_APPLY;
                end
                S_APPLY: begin
                    if (settle_q == 8'(SETTLE - 1)) begin
                        state_d = S_CHECK;
                    end else begin
                        settle_d = settle_q + 8'd1;
                    end
                end
                S_CHECK: begin
                    if (mismatch && (err_q != ERR_W'(N_VEC))) begin
                        err_d = err_q + ERR_W'(1);
                    end
                    lfsr_d = lfsr_nxt;
                    if (vec_q == 8'(N_VEC - 1)) begin
                        state_d = S_REPORT;
                    end else begin
                        vec_d    = vec_q + 8'd1;
                        settle_d = '0;
                        state_d  = S_APPLY;
                    end
                end
                S_REPORT: begin
                    if (res_ready_i) begin
                        if (k_q == 7'(KEY_W)) begin
                            key_d   = '0;
                            lfsr_d  = '0;
                            state_d = S_DONE;
                        end else begin
                            k_d     = k_q + 7'd1;
                            key_d   = base_q ^ (KEY_W'(1) << k_q);
                            lfsr_d  = seed_q;
                            vec_d   = '0;
                            err_d   = '0;
                            state_d = S_LOAD;
                        end
                    end
                end
                S_DONE: begin
                    k_d     = '0;
                    err_d   = '0;
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            key_q    <= '0;
            base_q   <= '0;
            lfsr_q   <= '0;
            seed_q   <= '0;
            k_q      <= '0;
            vec_q    <= '0;
            settle_q <= '0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            key_q    <= key_d;
            base_q   <= base_d;
            lfsr_q   <= lfsr_d;
            seed_q   <= seed_d;
            k_q      <= k_d;
            vec_q    <= vec_d;
            settle_q <= settle_d;
            err_q    <= err_d;
        end
    end

    // Outputs decoded from registered state.
    always_comb begin
        operand1_o  = lfsr_q[15:8];
        operand2_o  = lfsr_q[7:0];
        key_o       = key_q;
        res_valid_o = (state_q == S_REPORT);
        res_idx_o   = k_q;
        res_err_o   = err_q;
        busy_o      = (state_q != S_IDLE);
        done_o      = (state_q == S_DONE);
    end

endmodule

// File: tb/tb_locked_mult_key_scanner.sv
// Scoreboard bench for locked_mult_key_scanner.
// Ideal and locked multiplier models drive result_i.
module tb_locked_mult_key_scanner;

    localparam logic [63:0] MAGIC = 64'h3A7437252F48B327;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        start_i;
    logic        abort_i;
    logic [63:0] base_key_i;
    logic [15:0] seed_i;
    logic [7:0]  operand1_o;
    logic [7:0]  operand2_o;
    logic [63:0] key_o;
    logic [15:0] result_i;
    logic        res_valid_o;
    logic        res_ready_i;
    logic [6:0]  res_idx_o;
    logic [4:0]  res_err_o;
    logic        busy_o;
    logic        done_o;

    typedef struct {
        int          idx;
        int          err;
        logic [63:0] key;
    } rep_t;

    rep_t        exp_q[$];
    int          n_vec = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          t0;
    int          done_cnt = 0;
    int          done_cyc;
    bit          locked_mode = 1'b0;
    logic [15:0] prod;

    locked_mult_key_scanner dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .start_i     (start_i),
        .abort_i     (abort_i),
        .base_key_i  (base_key_i),
        .seed_i      (seed_i),
        .operand1_o  (operand1_o),
        .operand2_o  (operand2_o),
        .key_o       (key_o),
        .result_i    (result_i),
        .res_valid_o (res_valid_o),
        .res_ready_i (res_ready_i),
        .res_idx_o   (res_idx_o),
        .res_err_o   (res_err_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Multiplier model: ideal, or bit 0 inverted unless the key is right.
    always_comb begin
        prod = {8'd0, operand1_o} * {8'd0, operand2_o};
        result_i = prod;
        if (locked_mode && (key_o != MAGIC)) result_i = prod ^ 16'd1;
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    // Report consumer: pop expected entry on each accepted handshake.
    always @(negedge clk) begin
        if (res_valid_o && res_ready_i) begin
            if (exp_q.size() == 0) begin
                chk("spurious_idx", 64'(res_idx_o), 64'hFFFF);
            end else begin
                rep_t e;
                e = exp_q.pop_front();
                chk("rep_idx", 64'(res_idx_o), 64'(e.idx));
                chk("rep_err", 64'(res_err_o), 64'(e.err));
                chk("rep_key", key_o, e.key);
            end
        end
        if (done_o) done_cnt++;
    end

    task automatic push_sweep(input logic [63:0] base, input bit lk);
        for (int k = 0; k <= 64; k++) begin
            rep_t e;
            e.idx = k;
            e.key = (k == 0) ? base : base ^ (64'd1 << (k - 1));
            e.err = (lk && e.key != MAGIC) ? 16 : 0;
            exp_q.push_back(e);
        end
    endtask

    task automatic start_sweep(input logic [63:0] base, input logic [15:0] sd);
        @(posedge clk);
        #1;
        base_key_i = base;
        seed_i     = sd;
        start_i    = 1'b1;
        t0         = cyc;
        @(posedge clk);
        #1;
        start_i    = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        done_cyc = -1;
        while (!done_o && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", 64'(done_o), 64'd1);
        done_cyc = cyc;
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(posedge clk);
        #1;
    endtask

    initial begin
        int          d0;
        int          n;
        logic [15:0] v;
        rst_ni      = 1'b0;
        start_i     = 1'b0;
        abort_i     = 1'b0;
        base_key_i  = '0;
        seed_i      = '0;
        res_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_key", key_o, 64'd0);
        chk("rst_misc", {operand1_o, operand2_o, res_valid_o, res_idx_o,
                         res_err_o, busy_o, done_o}, 64'd0);
        rst_ni = 1'b1;

        // Reset asserted mid-APPLY.
        start_sweep(MAGIC, 16'h1234);
        @(posedge clk);
        #3;
        chk("pre_rst_busy", 64'(busy_o), 64'd1);
        rst_ni = 1'b0;
        #1;
        chk("midrst_key", key_o, 64'd0);
        chk("midrst_misc", {operand1_o, operand2_o, res_valid_o, res_idx_o,
                            res_err_o, busy_o, done_o}, 64'd0);
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_rst_busy", 64'(busy_o), 64'd0);

        // Ideal multiplier, full sweep and latency.
        locked_mode = 1'b0;
        push_sweep(MAGIC, 1'b0);
        d0 = done_cnt;
        start_sweep(MAGIC, 16'h1234);
        wait_done(4000);
        chk("done_lat", 64'(done_cyc - t0), 64'd3251);
        chk("done_key", key_o, 64'd0);
        chk("done_ops", {48'd0, operand1_o, operand2_o}, 64'd0);
        chk("done_busy", 64'(busy_o), 64'd1);
        @(negedge clk);
        chk("idle_busy", 64'(busy_o), 64'd0);
        chk("done_pulses", 64'(done_cnt - d0), 64'd1);
        chk("ideal_left", 64'(exp_q.size()), 64'd0);

        // Locked multiplier.
        locked_mode = 1'b1;
        push_sweep(MAGIC, 1'b1);
        start_sweep(MAGIC, 16'h1234);
        wait_done(4000);
        @(negedge clk);
        chk("locked_left", 64'(exp_q.size()), 64'd0);
        locked_mode = 1'b0;

        // Backpressure at idx 3, plus ignored start while busy.
        push_sweep(MAGIC, 1'b0);
        start_sweep(MAGIC, 16'h1234);
        wait_cyc(t0 + 100);
        base_key_i = 64'hFFFF_0000_FFFF_0000;
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        wait_cyc(t0 + 170);
        res_ready_i = 1'b0;
        n = 0;
        while (!res_valid_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("bp_valid", 64'(res_valid_o), 64'd1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", 64'(res_valid_o), 64'd1);
            chk("bp_hold_idx", 64'(res_idx_o), 64'd3);
            chk("bp_hold_err", 64'(res_err_o), 64'd0);
            chk("bp_hold_key", key_o, MAGIC ^ 64'd4);
        end
        @(posedge clk);
        #1;
        res_ready_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_adv_valid", 64'(res_valid_o), 64'd0);
        chk("bp_adv_idx", 64'(res_idx_o), 64'd4);
        wait_done(4000);
        @(negedge clk);
        chk("bp_left", 64'(exp_q.size()), 64'd0);

        // Abort during candidate 10.
        push_sweep(MAGIC, 1'b0);
        d0 = done_cnt;
        start_sweep(MAGIC, 16'h1234);
        wait_cyc(t0 + 511);
        abort_i = 1'b1;
        @(posedge clk);
        #1;
        abort_i = 1'b0;
        @(negedge clk);
        chk("abort_busy", 64'(busy_o), 64'd0);
        chk("abort_valid", 64'(res_valid_o), 64'd0);
        chk("abort_key", key_o, 64'd0);
        chk("abort_ops", {48'd0, operand1_o, operand2_o}, 64'd0);
        chk("abort_left", 64'(exp_q.size()), 64'd55);
        exp_q.delete();
        repeat (10) @(negedge clk);
        chk("abort_nodone", 64'(done_cnt - d0), 64'd0);

        // Restart with seed 0: substitute seed and vector sequence.
        push_sweep(64'h0123_4567_89AB_CDEF, 1'b0);
        start_sweep(64'h0123_4567_89AB_CDEF, 16'h0000);
        chk("seed0_ops", {48'd0, operand1_o, operand2_o}, 64'hACE1);
        chk("seed0_gold", 64'(result_i), 64'h972C);
        chk("seed0_key", key_o, 64'h0123_4567_89AB_CDEF);
        v = 16'hACE1;
        for (int j = 1; j <= 3; j++) begin
            v = lfsr_step(v);
            wait_cyc(t0 + 2 + 3 * j);
            chk("lfsr_vec", {48'd0, operand1_o, operand2_o}, 64'(v));
        end
        wait_done(4000);
        @(negedge clk);
        chk("seed0_left", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1);
    end

endmodule
